// File: rtl/spi_line_fetcher.sv
// rtl/spi_line_fetcher.sv - SPI flash line fetcher into a ping-pong bit buffer
// Quad-output read is built only when SPI_QUAD_EN is defined.
module spi_line_fetcher #(
    parameter int         DATA_BITS = 136,
    parameter int         IDX_W     = $clog2(DATA_BITS),
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_QREAD = 8'h6B,
    parameter int         QDUMMY    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic             quad,
    output logic             busy,
    output logic             done,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_data,
    output logic             spi_cs,
    output logic             spi_sclk,
    output logic [3:0]       spi_out,
    output logic [3:0]       spi_oe,
    input  logic [3:0]       spi_in
);
`ifdef SPI_QUAD_EN
    localparam bit QUAD_EN = 1'b1;
`else
    localparam bit QUAD_EN = 1'b0;
`endif
    localparam int CNT_W = (IDX_W > 5) ? IDX_W : 5;
    localparam logic [CNT_W-1:0] LAST_SINGLE = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_QUAD   = CNT_W'(DATA_BITS / 4 - 1);
    localparam logic [CNT_W-1:0] LAST_DUMMY  = CNT_W'(QDUMMY - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA} state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   done_nx;
    logic [31:0]            sh;
    logic                   quad_q;
    logic                   quad_eff;
    logic                   front;
    logic                   back;
    logic [3:0]             miso_q;
    logic [IDX_W-1:0]       qbase;
    logic [DATA_BITS-1:0]   bank [2];

    assign quad_eff = QUAD_EN & quad;
    assign back     = ~front;
    assign qbase    = {cnt[IDX_W-3:0], 2'b00};
    assign spi_sclk = ~clk;
    assign rd_data  = (32'(rd_index) < 32'(DATA_BITS)) ? bank[front][rd_index] : 1'b0;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        done_nx  = 1'b0;
        busy     = (state != S_IDLE);
        spi_cs   = (state != S_IDLE);
        spi_out  = 4'b0000;
        spi_oe   = 4'b0001;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (start) state_nx = S_CMD;
            end
            S_CMD: begin
                spi_out[0] = sh[31];
                if (cnt == CNT_W'(7)) begin
                    state_nx = S_ADDR;
                    cnt_nx   = '0;
                end
            end
            S_ADDR: begin
                spi_out[0] = sh[31];
                if (cnt == CNT_W'(23)) begin
                    state_nx = (quad_q && QDUMMY > 0) ? S_DUMMY : S_DATA;
                    cnt_nx   = '0;
                end
            end
            S_DUMMY: begin
                if (quad_q) spi_oe = 4'b0000;
                if (cnt == LAST_DUMMY) begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                end
            end
            S_DATA: begin
                if (quad_q) spi_oe = 4'b0000;
                if (cnt == (quad_q ? LAST_QUAD : LAST_SINGLE)) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            sh     <= '0;
            quad_q <= 1'b0;
            front  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
            if (done_nx) front <= ~front;
            if (state == S_IDLE && start) begin
                sh     <= {(quad_eff ? CMD_QREAD : CMD_READ), addr};
                quad_q <= quad_eff;
            end else if (state == S_CMD || state == S_ADDR) begin
                sh <= {sh[30:0], 1'b0};
            end
        end
    end

    // Flash drives on sclk fall; capture on sclk rise, i.e. mid-cycle on clk fall.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n)
            miso_q <= '0;
        else if (state == S_DATA)
            miso_q <= spi_in;
    end

    always_ff @(posedge clk) begin
        if (state == S_DATA) begin
            if (quad_q) begin
                bank[back][qbase]               <= miso_q[3];
                bank[back][qbase + IDX_W'(1)]   <= miso_q[2];
                bank[back][qbase + IDX_W'(2)]   <= miso_q[1];
                bank[back][qbase + IDX_W'(3)]   <= miso_q[0];
            end else begin
                bank[back][cnt[IDX_W-1:0]] <= miso_q[1];
            end
        end
    end
endmodule

// File: tb/tb_spi_line_fetcher.sv
// tb/tb_spi_line_fetcher.sv - scoreboard bench for spi_line_fetcher with a behavioural SPI flash
`timescale 1ns/1ps
module tb_spi_line_fetcher;
    localparam int DATA_BITS  = 136;
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam int QDUMMY     = 8;
    localparam int LAT_SINGLE = 1 + 32 + DATA_BITS;
    localparam int LAT_QUAD   = 1 + 32 + QDUMMY + DATA_BITS / 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [23:0]      addr = '0;
    logic             quad = 1'b0;
    logic [IDX_W-1:0] rd_index = '0;
    logic             busy, done, rd_data, spi_cs, spi_sclk;
    logic [3:0]       spi_out, spi_oe;
    logic [3:0]       spi_in = 4'h0;

    spi_line_fetcher dut (
        .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .quad(quad),
        .busy(busy), .done(done), .rd_index(rd_index), .rd_data(rd_data),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_out(spi_out), .spi_oe(spi_oe),
        .spi_in(spi_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_pulses = 0;
    always @(negedge clk) if (done === 1'b1) done_pulses++;

    // Flash model: shifts in CMD+ADDR on sclk rise, drives data after sclk fall.
    logic [7:0]  mem [0:511];
    int          m_n = 0;
    int          m_j;
    logic [7:0]  m_b;
    logic [31:0] m_sr = '0;

    always @(negedge clk) begin
        if (spi_cs === 1'b1) begin
            if (m_n < 32) m_sr = {m_sr[30:0], spi_out[0]};
            if (m_n == 32) begin
                check("oe_after_addr", spi_oe, (m_sr[31:24] == 8'h6B) ? 4'h0 : 4'h1);
                check("out_after_addr", spi_out, 4'h0);
            end
            m_n++;
        end else begin
            m_n = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        spi_in = 4'($urandom);
        if (spi_cs === 1'b1 && m_n >= 32) begin
            if (m_sr[31:24] == 8'h6B) begin
                if (m_n >= 32 + QDUMMY) begin
                    m_j = m_n - 32 - QDUMMY;
                    m_b = mem[9'(m_sr[23:0] + 24'(m_j / 2))];
                    spi_in = (m_j % 2 == 0) ? m_b[7:4] : m_b[3:0];
                end
            end else begin
                m_j = m_n - 32;
                m_b = mem[9'(m_sr[23:0] + 24'(m_j / 8))];
                spi_in[1] = m_b[7 - (m_j % 8)];
            end
        end
    end

    typedef struct {
        logic [255:0] line;
        logic [7:0]   cmd;
        logic [23:0]  addr;
        int           lat;
        int           t0;
    } exp_t;
    exp_t sb[$];

    function automatic logic [255:0] exp_line(input logic [23:0] a);
        logic [255:0] l;
        logic [7:0]   b;
        l = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            b = mem[9'(a + 24'(i / 8))];
            l[i] = b[7 - (i % 8)];
        end
        return l;
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic read_line(output logic [255:0] l);
        l = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            rd_index = IDX_W'(i);
            #0.01;
            l[i] = rd_data;
        end
    endtask

    task automatic issue(input logic [23:0] a, input logic q);
        exp_t e;
        start = 1'b1;
        addr  = a;
        quad  = q;
        e.addr = a;
        e.line = exp_line(a);
        e.t0   = cyc;
`ifdef SPI_QUAD_EN
        e.cmd = q ? 8'h6B : 8'h03;
        e.lat = q ? LAT_QUAD : LAT_SINGLE;
`else
        e.cmd = 8'h03;
        e.lat = LAT_SINGLE;
`endif
        sb.push_back(e);
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        exp_t         e;
        logic [255:0] got;
        int           n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick;
            n++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("cmd", m_sr[31:24], e.cmd);
        check("addr", m_sr[23:0], e.addr);
        check("latency", cyc - e.t0, e.lat);
        check("cs_at_done", spi_cs, 0);
        check("busy_at_done", busy, 0);
        read_line(got);
        check("line", got, e.line);
    endtask

    logic [255:0] got;
    logic [15:0]  head;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[9'h120] = 8'hA5;
        mem[9'h121] = 8'h3C;
        mem[9'h040] = 8'h5A;

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", spi_cs, 0);
        check("rst_out", spi_out, 4'h0);
        check("rst_oe", spi_oe, 4'h1);
        reset_n = 1'b1;
        tick;

        // Fetch aborted by reset during ADDR: not on the scoreboard, must never complete.
        start = 1'b1;
        addr  = 24'h000120;
        tick;
        start = 1'b0;
        repeat (15) tick;
        check("abort_cs_before", spi_cs, 1);
        #1 reset_n = 1'b0;
        #0.5;
        check("abort_cs", spi_cs, 0);
        check("abort_busy", busy, 0);
        tick;
        reset_n = 1'b1;
        repeat (3) tick;

        issue(24'h000120, 1'b0);
        wait_done(400);
        for (int i = 0; i < 16; i++) begin
            rd_index = IDX_W'(i);
            #0.01;
            head[i] = rd_data;
        end
        check("first_bits", head, 16'h3CA5);
        rd_index = IDX_W'(DATA_BITS);
        #0.01;
        check("idx_data_bits", rd_data, 0);
        rd_index = '1;
        #0.01;
        check("idx_max", rd_data, 0);

        issue(24'h000000, 1'b0);
        wait_done(400);
        issue(24'h000010, 1'b0);
        repeat (48) tick;
        start = 1'b1;
        addr  = 24'hABCDEF;
        tick;
        start = 1'b0;
        repeat (50) tick;
        check("busy_mid", busy, 1);
        read_line(got);
        check("front_during_fetch", got, exp_line(24'h000000));
        wait_done(400);

        issue(24'h000120, 1'b0);
        wait_done(400);
        issue(24'h000000, 1'b0);
        check("b2b_cs", spi_cs, 1);
        wait_done(400);

`ifdef SPI_QUAD_EN
        issue(24'h000040, 1'b1);
        repeat (20) tick;
        quad = 1'b0;
        wait_done(400);
        for (int i = 0; i < 8; i++) begin
            rd_index = IDX_W'(i);
            #0.01;
            head[i] = rd_data;
        end
        check("quad_bits", head[7:0], 8'h5A);
`else
        issue(24'h000040, 1'b1);
        quad = 1'b0;
        wait_done(400);
`endif

        repeat (3) tick;
        check("done_pulses", done_pulses, 6);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
